// File: rtl/inference_sequencer.sv
// Start/done initiator for the inference accelerator: runs a batch of back-to-back
// inferences with an optional per-run timeout and keeps latency statistics.
module inference_sequencer #(
    parameter int WIDTH  = 16,
    parameter int RUNS_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic [RUNS_W-1:0]       num_runs,
    input  logic [WIDTH-1:0]        timeout_cycles,
    output logic                    start,
    input  logic                    done,
    output logic                    busy,
    output logic                    batch_done,
    output logic                    timeout_flag,
    output logic [WIDTH-1:0]        last_latency,
    output logic [WIDTH-1:0]        min_latency,
    output logic [WIDTH-1:0]        max_latency,
    output logic [WIDTH+RUNS_W-1:0] sum_latency,
    output logic [RUNS_W-1:0]       runs_completed
);

    localparam int SUM_W = WIDTH + RUNS_W;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [RUNS_W-1:0] num_runs_q, num_runs_d;
    logic [WIDTH-1:0]  timeout_q, timeout_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              batch_done_q, batch_done_d;
    logic              timeout_flag_q, timeout_flag_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic [WIDTH-1:0]  min_q, min_d;
    logic [WIDTH-1:0]  max_q, max_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [RUNS_W-1:0] runs_q, runs_d;

    logic [WIDTH-1:0]  lat;
    logic              timeout_hit;
    logic              last_run;

    // A saturated counter reports a saturated latency rather than wrapping to 0.
    assign lat         = (cnt_q == ALL_ONES) ? ALL_ONES : cnt_q + WIDTH'(1);
    assign timeout_hit = (state_q == S_WAIT) && !done && (timeout_q != '0)
                         && ((cnt_q + WIDTH'(1)) == timeout_q);
    assign last_run    = (runs_q + RUNS_W'(1)) == num_runs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            num_runs_q     <= '0;
            timeout_q      <= '0;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            batch_done_q   <= 1'b0;
            timeout_flag_q <= 1'b0;
            last_q         <= '0;
            min_q          <= ALL_ONES;
            max_q          <= '0;
            sum_q          <= '0;
            runs_q         <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            num_runs_q     <= num_runs_d;
            timeout_q      <= timeout_d;
            start_q        <= start_d;
            busy_q         <= busy_d;
            batch_done_q   <= batch_done_d;
            timeout_flag_q <= timeout_flag_d;
            last_q         <= last_d;
            min_q          <= min_d;
            max_q          <= max_d;
            sum_q          <= sum_d;
            runs_q         <= runs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (go) state_d = (num_runs == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT: begin
                if (done)             state_d = last_run ? S_FINISH : S_GAP;
                else if (timeout_hit) state_d = S_FINISH;
            end
            S_GAP:    state_d = S_ISSUE;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_comb begin
        cnt_d          = cnt_q;
        num_runs_d     = num_runs_q;
        timeout_d      = timeout_q;
        timeout_flag_d = timeout_flag_q;
        last_d         = last_q;
        min_d          = min_q;
        max_d          = max_q;
        sum_d          = sum_q;
        runs_d         = runs_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    num_runs_d     = num_runs;
                    timeout_d      = timeout_cycles;
                    timeout_flag_d = 1'b0;
                    last_d         = '0;
                    min_d          = ALL_ONES;
                    max_d          = '0;
                    sum_d          = '0;
                    runs_d         = '0;
                end
            end
            S_ISSUE: cnt_d = '0;
            S_WAIT: begin
                if (done) begin
                    last_d = lat;
                    if (lat < min_q) min_d = lat;
                    if (lat > max_q) max_d = lat;
                    sum_d  = sum_q + SUM_W'(lat);
                    runs_d = runs_q + RUNS_W'(1);
                end else if (timeout_hit) begin
                    timeout_flag_d = 1'b1;
                end else if (cnt_q != ALL_ONES) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: ;
        endcase
        start_d      = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
        batch_done_d = (state_d == S_FINISH);
    end

    assign start          = start_q;
    assign busy           = busy_q;
    assign batch_done     = batch_done_q;
    assign timeout_flag   = timeout_flag_q;
    assign last_latency   = last_q;
    assign min_latency    = min_q;
    assign max_latency    = max_q;
    assign sum_latency    = sum_q;
    assign runs_completed = runs_q;

endmodule
